// File: rtl/l1a_trigger_gate_pkg.sv
// L1A trigger gate shared types.
// FSM states, veto cause codes and a cause encoder.
package l1a_trigger_gate_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  localparam logic [1:0] VETO_NONE    = 2'b00;
  localparam logic [1:0] VETO_HOLDOFF = 2'b01;
  localparam logic [1:0] VETO_STOP    = 2'b10;

  function automatic logic [1:0] veto_code(
    input logic hold,
    input logic stop
  );
    return (hold ? VETO_HOLDOFF : VETO_NONE)
         | (stop ? VETO_STOP : VETO_NONE);
  endfunction

endpackage

// File: rtl/l1a_trigger_gate_if.sv
// L1A trigger gate signal bundle.
// master drives live/trig/stop, slave is the gate.
interface l1a_trigger_gate_if #(
  parameter int EVID_W = 16,
  parameter int CNT_W  = 32
);
  logic              live;
  logic              trig_in;
  logic              stop;
  logic              live_rising;
  logic              trig_accepted;
  logic              trig_vetoed;
  logic [1:0]        veto_cause;
  logic [EVID_W-1:0] event_id;
  logic [CNT_W-1:0]  n_accepted;
  logic [CNT_W-1:0]  n_vetoed;
  logic              busy;

  modport master (
    output live, trig_in, stop,
    input  live_rising, trig_accepted, trig_vetoed,
    input  veto_cause, event_id, n_accepted,
    input  n_vetoed, busy
  );

  modport slave (
    input  live, trig_in, stop,
    output live_rising, trig_accepted, trig_vetoed,
    output veto_cause, event_id, n_accepted,
    output n_vetoed, busy
  );
endinterface

// File: rtl/l1a_trigger_gate_sync_edge.sv
// Two-flop synchroniser with rising-edge detect.
// Reusable for any asynchronous front-panel level.
module l1a_trigger_gate_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic       s1, s2, s3;
  logic [1:0] fill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      fill <= 2'd0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
      if (fill != 2'd3) fill <= fill + 2'd1;
    end
  end

  // a level held through reset must not look like a fresh edge
  assign rise = s2 & ~s3 & (fill == 2'd3);

endmodule

// File: rtl/l1a_trigger_gate.sv
// L1A trigger qualifier: live window, pile-up stop, holdoff.
// Emits accept/veto pulses, event ids and run counters.
module l1a_trigger_gate
  import l1a_trigger_gate_pkg::*;
#(
  parameter int HOLDOFF_CYC = 16,
  parameter int EVID_W      = 16,
  parameter int CNT_W       = 32
) (
  input logic          clk,
  input logic          rst_n,
  l1a_trigger_gate_if.slave bus
);
  localparam int HW =
    (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
  localparam logic [HW-1:0] HLOAD =
    HW'(HOLDOFF_CYC - 1);

  state_t            state, state_n;
  logic [HW-1:0]     hcnt, hcnt_n;
  logic              live_d, trig_edge, qual;
  logic              rise_q, rise_n;
  logic              acc_q, acc_n;
  logic              veto_q, veto_n;
  logic [1:0]        cause_q, cause_n;
  logic [EVID_W-1:0] evid_q, evid_n;
  logic [CNT_W-1:0]  nacc_q, nacc_n;
  logic [CNT_W-1:0]  nveto_q, nveto_n;

  l1a_trigger_gate_sync_edge u_trig (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (bus.trig_in),
    .rise (trig_edge)
  );

  assign rise_n = bus.live & ~live_d;
  // edges landing in the live_rising cycle are dropped
  assign qual = trig_edge & bus.live & ~rise_q;

  always_comb begin
    state_n = state;
    hcnt_n  = hcnt;
    acc_n   = 1'b0;
    veto_n  = 1'b0;
    cause_n = VETO_NONE;
    evid_n  = evid_q;
    nacc_n  = nacc_q;
    nveto_n = nveto_q;
    unique case (state)
      ST_IDLE: begin
        if (bus.live) state_n = ST_ARMED;
      end
      ST_ARMED: begin
        if (qual && bus.stop) begin
          veto_n  = 1'b1;
          cause_n = veto_code(1'b0, bus.stop);
        end else if (qual) begin
          acc_n   = 1'b1;
          hcnt_n  = HLOAD;
          state_n = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        if (hcnt == '0) state_n = ST_ARMED;
        else hcnt_n = hcnt - HW'(1);
        if (qual) begin
          veto_n  = 1'b1;
          cause_n = veto_code(1'b1, bus.stop);
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (!bus.live) state_n = ST_IDLE;
    if (acc_n) begin
      evid_n = evid_q + EVID_W'(1);
      if (nacc_q != '1) nacc_n = nacc_q + CNT_W'(1);
    end
    if (veto_n && nveto_q != '1)
      nveto_n = nveto_q + CNT_W'(1);
    // cleared to all-ones so the first accept gets id 0
    if (rise_n) begin
      evid_n  = '1;
      nacc_n  = '0;
      nveto_n = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      hcnt    <= '0;
      live_d  <= 1'b0;
      rise_q  <= 1'b0;
      acc_q   <= 1'b0;
      veto_q  <= 1'b0;
      cause_q <= VETO_NONE;
      evid_q  <= '0;
      nacc_q  <= '0;
      nveto_q <= '0;
    end else begin
      state   <= state_n;
      hcnt    <= hcnt_n;
      live_d  <= bus.live;
      rise_q  <= rise_n;
      acc_q   <= acc_n;
      veto_q  <= veto_n;
      cause_q <= cause_n;
      evid_q  <= evid_n;
      nacc_q  <= nacc_n;
      nveto_q <= nveto_n;
    end
  end

  assign bus.live_rising   = rise_q;
  assign bus.trig_accepted = acc_q;
  assign bus.trig_vetoed   = veto_q;
  assign bus.veto_cause    = cause_q;
  assign bus.event_id      = evid_q;
  assign bus.n_accepted    = nacc_q;
  assign bus.n_vetoed      = nveto_q;
  assign bus.busy          = (state == ST_HOLDOFF);

endmodule

// File: tb/tb_l1a_trigger_gate.sv
// Bench for l1a_trigger_gate: two instances (wide and 4-bit
// id/counters) against an edge-indexed reference model.
module tb_l1a_trigger_gate;
  localparam int HOLD = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  l1a_trigger_gate_if #(.EVID_W(16), .CNT_W(32)) ia ();
  l1a_trigger_gate_if #(.EVID_W(4), .CNT_W(4)) ib ();

  l1a_trigger_gate #(
    .HOLDOFF_CYC(HOLD), .EVID_W(16), .CNT_W(32)
  ) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));

  l1a_trigger_gate #(
    .HOLDOFF_CYC(HOLD), .EVID_W(4), .CNT_W(4)
  ) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

  int n_tot, n_bad;

  logic [85:0] obs_a, exp_a;
  logic [17:0] obs_b, exp_b;
  assign obs_a = {ia.live_rising, ia.trig_accepted,
                  ia.trig_vetoed, ia.veto_cause, ia.busy,
                  ia.event_id, ia.n_accepted, ia.n_vetoed};
  assign obs_b = {ib.live_rising, ib.trig_accepted,
                  ib.trig_vetoed, ib.veto_cause, ib.busy,
                  ib.event_id, ib.n_accepted, ib.n_vetoed};

  // model: k = edge index since reset release, tq = trig samples,
  // r_idx = edge where live rose, a_idx = edge of last accept
  int  k, r_idx, a_idx, nacc, nveto, eid;
  bit  lprev;
  bit  tq[$];

  function automatic logic [3:0] sat4(int v);
    return (v > 15) ? 4'd15 : 4'(v);
  endfunction

  function automatic int seg(int n, bit l, bit t, bit s);
    return {n[28:0], l, t, s};
  endfunction

  task automatic model_reset();
    k = 0; r_idx = -1; a_idx = -1000;
    nacc = 0; nveto = 0; eid = 0; lprev = 1'b0;
    tq.delete();
    exp_a = '0; exp_b = '0;
  endtask

  task automatic model_step();
    bit li, ti, si, hold, lr, acc, veto, busy;
    logic [1:0] cause;
    int j;
    li = ia.live; ti = ia.trig_in; si = ia.stop; j = k;
    tq.push_back(ti);
    lr = li && !lprev;
    acc = 1'b0; veto = 1'b0; cause = 2'b00;
    if (!li) a_idx = -1000;
    if (lr) begin
      r_idx = j; nacc = 0; nveto = 0; eid = -1;
    end else if (li && r_idx >= 0 && j >= r_idx + 2 && j >= 3
                 && tq[j-2] && !tq[j-3]) begin
      hold = (j - a_idx >= 1) && (j - a_idx <= HOLD);
      if (hold || si) begin
        veto = 1'b1; nveto++;
        cause = hold ? {si, 1'b1} : 2'b10;
      end else begin
        acc = 1'b1; a_idx = j; nacc++; eid++;
      end
    end
    busy = li && (j - a_idx >= 0) && (j - a_idx < HOLD);
    exp_a = {lr, acc, veto, cause, busy, 16'(eid),
             32'(nacc), 32'(nveto)};
    exp_b = {lr, acc, veto, cause, busy, 4'(eid),
             sat4(nacc), sat4(nveto)};
    lprev = li;
    k++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
  endtask

  task automatic drive(int sg);
    ia.live = sg[2]; ia.trig_in = sg[1]; ia.stop = sg[0];
    ib.live = sg[2]; ib.trig_in = sg[1]; ib.stop = sg[0];
  endtask

  task automatic release_rst();
    #4 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    drive(seg(0, 1, 1, 1));
    repeat (3) begin
      tick();
      n_tot += 2;
      if (obs_a !== '0) begin
        n_bad++;
        $display("FAIL reset_a got=%h want=0", obs_a);
      end
      if (obs_b !== '0) begin
        n_bad++;
        $display("FAIL reset_b got=%h want=0", obs_b);
      end
    end
    drive(seg(0, 0, 0, 0));
    release_rst();
  endtask

  task automatic test_single();
    int tbl[4] = '{seg(4, 0, 0, 0), seg(6, 1, 0, 0),
                   seg(5, 1, 1, 0), seg(30, 1, 0, 0)};
    int nb = 0, na = 0, nl = 0;
    foreach (tbl[i]) begin
      drive(tbl[i]);
      repeat (tbl[i] >> 3) begin
        tick();
        if (ia.busy) nb++;
        if (ia.trig_accepted) na++;
        if (ia.live_rising) nl++;
        n_tot += 2;
        if (obs_a !== exp_a) begin
          n_bad++;
          $display("FAIL single_a k=%0d got=%h want=%h", k, obs_a, exp_a);
        end
        if (obs_b !== exp_b) begin
          n_bad++;
          $display("FAIL single_b k=%0d got=%h want=%h", k, obs_b, exp_b);
        end
      end
    end
    n_tot += 5;
    if (nb != 16) begin n_bad++; $display("FAIL busy_len got=%0d want=16", nb); end
    if (na != 1) begin n_bad++; $display("FAIL single_acc got=%0d want=1", na); end
    if (nl != 1) begin n_bad++; $display("FAIL single_lr got=%0d want=1", nl); end
    if (ia.event_id !== 16'd0) begin
      n_bad++; $display("FAIL single_id got=%0d want=0", ia.event_id);
    end
    if (ia.n_accepted !== 32'd1) begin
      n_bad++; $display("FAIL single_nacc got=%0d want=1", ia.n_accepted);
    end
  endtask

  task automatic test_holdoff();
    int tbl[8] = '{seg(2, 0, 0, 0), seg(3, 1, 0, 0),
                   seg(4, 1, 1, 0), seg(4, 1, 0, 0),
                   seg(4, 1, 1, 0), seg(8, 1, 0, 0),
                   seg(4, 1, 1, 0), seg(25, 1, 0, 0)};
    int nc = 0;
    foreach (tbl[i]) begin
      drive(tbl[i]);
      repeat (tbl[i] >> 3) begin
        tick();
        if (ia.trig_vetoed && ia.veto_cause == 2'b01) nc++;
        n_tot += 2;
        if (obs_a !== exp_a) begin
          n_bad++;
          $display("FAIL holdoff_a k=%0d got=%h want=%h", k, obs_a, exp_a);
        end
        if (obs_b !== exp_b) begin
          n_bad++;
          $display("FAIL holdoff_b k=%0d got=%h want=%h", k, obs_b, exp_b);
        end
      end
    end
    n_tot += 4;
    if (nc != 1) begin n_bad++; $display("FAIL holdoff_cause got=%0d want=1", nc); end
    if (ia.n_vetoed !== 32'd1) begin
      n_bad++; $display("FAIL holdoff_nveto got=%0d want=1", ia.n_vetoed);
    end
    if (ia.event_id !== 16'd1) begin
      n_bad++; $display("FAIL holdoff_id got=%0d want=1", ia.event_id);
    end
    if (ia.n_accepted !== 32'd2) begin
      n_bad++; $display("FAIL holdoff_nacc got=%0d want=2", ia.n_accepted);
    end
  endtask

  task automatic test_stop();
    int tbl[9] = '{seg(2, 0, 0, 1), seg(4, 1, 0, 1),
                   seg(4, 1, 1, 1), seg(4, 1, 0, 1),
                   seg(4, 1, 1, 1), seg(4, 1, 0, 1),
                   seg(4, 1, 1, 1), seg(4, 1, 0, 1),
                   seg(4, 1, 0, 0)};
    int nb = 0, nc = 0;
    foreach (tbl[i]) begin
      drive(tbl[i]);
      repeat (tbl[i] >> 3) begin
        tick();
        if (ia.busy) nb++;
        if (ia.trig_vetoed && ia.veto_cause == 2'b10) nc++;
        n_tot += 2;
        if (obs_a !== exp_a) begin
          n_bad++;
          $display("FAIL stop_a k=%0d got=%h want=%h", k, obs_a, exp_a);
        end
        if (obs_b !== exp_b) begin
          n_bad++;
          $display("FAIL stop_b k=%0d got=%h want=%h", k, obs_b, exp_b);
        end
      end
    end
    n_tot += 4;
    if (nb != 0) begin n_bad++; $display("FAIL stop_busy got=%0d want=0", nb); end
    if (nc != 3) begin n_bad++; $display("FAIL stop_cause got=%0d want=3", nc); end
    if (ia.n_vetoed !== 32'd3) begin
      n_bad++; $display("FAIL stop_nveto got=%0d want=3", ia.n_vetoed);
    end
    if (ia.n_accepted !== 32'd0) begin
      n_bad++; $display("FAIL stop_nacc got=%0d want=0", ia.n_accepted);
    end
  endtask

  task automatic test_live_drop();
    int tbl[10] = '{seg(2, 0, 0, 0), seg(3, 1, 0, 0),
                    seg(4, 1, 1, 0), seg(5, 1, 0, 0),
                    seg(6, 0, 0, 0), seg(4, 0, 1, 0),
                    seg(4, 0, 0, 0), seg(3, 1, 0, 0),
                    seg(4, 1, 1, 0), seg(25, 1, 0, 0)};
    int np = 0;
    foreach (tbl[i]) begin
      drive(tbl[i]);
      repeat (tbl[i] >> 3) begin
        tick();
        if (i >= 4 && i <= 6 && (ia.trig_accepted || ia.trig_vetoed || ia.busy))
          np++;
        n_tot += 2;
        if (obs_a !== exp_a) begin
          n_bad++;
          $display("FAIL drop_a k=%0d got=%h want=%h", k, obs_a, exp_a);
        end
        if (obs_b !== exp_b) begin
          n_bad++;
          $display("FAIL drop_b k=%0d got=%h want=%h", k, obs_b, exp_b);
        end
      end
      if (i == 6) begin
        n_tot++;
        if (ia.n_accepted !== 32'd1) begin
          n_bad++; $display("FAIL drop_frozen got=%0d want=1", ia.n_accepted);
        end
      end
    end
    n_tot += 3;
    if (np != 0) begin n_bad++; $display("FAIL drop_idle got=%0d want=0", np); end
    if (ia.event_id !== 16'd0) begin
      n_bad++; $display("FAIL drop_id got=%0d want=0", ia.event_id);
    end
    if (ia.n_accepted !== 32'd1) begin
      n_bad++; $display("FAIL drop_nacc got=%0d want=1", ia.n_accepted);
    end
  endtask

  task automatic test_reset_mid();
    int pre[4] = '{seg(2, 0, 0, 0), seg(3, 1, 0, 0),
                   seg(6, 1, 1, 0), seg(0, 1, 1, 0)};
    int na = 0;
    for (int r = 0; r < 2; r++) begin
      foreach (pre[i]) begin
        drive(r == 1 && i < 3 ? seg(0, 1, 0, 0) : pre[i]);
        repeat (r == 1 ? (i == 3 ? 1 : 2) : (pre[i] >> 3)) begin
          tick();
          n_tot += 2;
          if (obs_a !== exp_a) begin
            n_bad++;
            $display("FAIL rstmid_a k=%0d got=%h want=%h", k, obs_a, exp_a);
          end
          if (obs_b !== exp_b) begin
            n_bad++;
            $display("FAIL rstmid_b k=%0d got=%h want=%h", k, obs_b, exp_b);
          end
        end
      end
      if (r == 0) begin
        n_tot++;
        if (!ia.busy) begin
          n_bad++; $display("FAIL rstmid_busy got=0 want=1");
        end
      end
      #4 rst_n = 1'b0;
      #1;
      n_tot += 2;
      if (obs_a !== '0) begin
        n_bad++; $display("FAIL rstmid_async_a got=%h want=0", obs_a);
      end
      if (obs_b !== '0) begin
        n_bad++; $display("FAIL rstmid_async_b got=%h want=0", obs_b);
      end
      repeat (2) tick();
      release_rst();
      drive(seg(0, 1, 1, 0));
      repeat (20) begin
        tick();
        if (ia.trig_accepted || ib.trig_accepted) na++;
        n_tot += 2;
        if (obs_a !== exp_a) begin
          n_bad++;
          $display("FAIL rstrel_a k=%0d got=%h want=%h", k, obs_a, exp_a);
        end
        if (obs_b !== exp_b) begin
          n_bad++;
          $display("FAIL rstrel_b k=%0d got=%h want=%h", k, obs_b, exp_b);
        end
      end
    end
    n_tot++;
    if (na != 0) begin n_bad++; $display("FAIL rst_spurious got=%0d want=0", na); end
    drive(seg(0, 1, 0, 0));
    repeat (4) tick();
  endtask

  task automatic test_wrap();
    int tbl[2] = '{seg(3, 1, 1, 0), seg(22, 1, 0, 0)};
    int nw = 0;
    drive(seg(0, 0, 0, 0));
    repeat (2) tick();
    drive(seg(0, 1, 0, 0));
    repeat (3) tick();
    for (int p = 0; p < 17; p++) begin
      foreach (tbl[i]) begin
        drive(tbl[i]);
        repeat (tbl[i] >> 3) begin
          tick();
          if (ib.trig_accepted) nw++;
          n_tot += 2;
          if (obs_a !== exp_a) begin
            n_bad++;
            $display("FAIL wrap_a k=%0d got=%h want=%h", k, obs_a, exp_a);
          end
          if (obs_b !== exp_b) begin
            n_bad++;
            $display("FAIL wrap_b k=%0d got=%h want=%h", k, obs_b, exp_b);
          end
        end
      end
    end
    n_tot += 5;
    if (nw != 17) begin n_bad++; $display("FAIL wrap_cnt got=%0d want=17", nw); end
    if (ib.event_id !== 4'd0) begin
      n_bad++; $display("FAIL wrap_id got=%0d want=0", ib.event_id);
    end
    if (ib.n_accepted !== 4'd15) begin
      n_bad++; $display("FAIL wrap_sat got=%0d want=15", ib.n_accepted);
    end
    if (ia.event_id !== 16'd16) begin
      n_bad++; $display("FAIL wide_id got=%0d want=16", ia.event_id);
    end
    if (ia.n_accepted !== 32'd17) begin
      n_bad++; $display("FAIL wide_nacc got=%0d want=17", ia.n_accepted);
    end
  endtask

  task automatic test_random();
    int tl = 0;
    bit t = 1'b0, l = 1'b1, s = 1'b0;
    repeat (1500) begin
      if (tl == 0) begin
        t = !t;
        tl = t ? int'($urandom_range(3, 8)) : int'($urandom_range(3, 20));
      end
      tl--;
      if (l && $urandom_range(0, 149) == 0) l = 1'b0;
      else if (!l && $urandom_range(0, 7) == 0) l = 1'b1;
      s = ($urandom_range(0, 4) == 0);
      drive(seg(0, l, t, s));
      tick();
      n_tot += 3;
      if (obs_a !== exp_a) begin
        n_bad++;
        $display("FAIL rand_a k=%0d got=%h want=%h", k, obs_a, exp_a);
      end
      if (obs_b !== exp_b) begin
        n_bad++;
        $display("FAIL rand_b k=%0d got=%h want=%h", k, obs_b, exp_b);
      end
      if (ia.trig_accepted && ia.trig_vetoed) begin
        n_bad++;
        $display("FAIL rand_excl k=%0d got=both want=one", k);
      end
    end
  endtask

  initial begin
    n_tot = 0;
    n_bad = 0;
    drive(seg(0, 0, 0, 0));
    model_reset();
    test_reset();
    test_single();
    test_holdoff();
    test_stop();
    test_live_drop();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
